// File: rtl/shift_out_register.sv
// Parallel-in, serial-out register: drains a loaded word LSB first over a valid/ready bit stream.
// Define PARITY_EN to append an even-parity beat (carrying bit_last) after the data bits.
module shift_out_register #(
   parameter int N = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic [N-1:0] data,
   output logic         bit_out,
   output logic         bit_valid,
   input  logic         bit_ready,
   output logic         bit_last,
   output logic         busy
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

`ifdef PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
   typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

   state_t        state_q, state_d;
   logic [N-1:0]  shift_q, shift_d;
   logic [CW-1:0] cnt_q,   cnt_d;
`ifdef PARITY_EN
   logic          parity_q, parity_d;
`endif

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
`ifdef PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         IDLE: begin
            if (load_valid) begin
               shift_d  = data;
               cnt_d    = CW'(N - 1);
`ifdef PARITY_EN
               parity_d = ^data;
`endif
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            if (bit_ready) begin
               shift_d = {1'b0, shift_q[N-1:1]};
               // Counter saturates at zero; the zero beat is the last data beat.
               if (cnt_q == '0) begin
`ifdef PARITY_EN
                  state_d = PARITY;
`else
                  state_d = IDLE;
`endif
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
         end
`ifdef PARITY_EN
         PARITY: begin
            if (bit_ready) state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
`ifdef PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
`ifdef PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Outputs decode registered state only, so no input reaches an output combinationally.
   always_comb begin
      load_ready = 1'b0;
      bit_valid  = 1'b0;
      bit_out    = 1'b0;
      bit_last   = 1'b0;
      busy       = 1'b1;
      case (state_q)
         IDLE: begin
            load_ready = 1'b1;
            busy       = 1'b0;
         end
         SHIFT: begin
            bit_valid = 1'b1;
            bit_out   = shift_q[0];
`ifndef PARITY_EN
            bit_last  = (cnt_q == '0);
`endif
         end
`ifdef PARITY_EN
         PARITY: begin
            bit_valid = 1'b1;
            bit_out   = parity_q;
            bit_last  = 1'b1;
         end
`endif
         default: busy = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_shift_out_register.sv
// Directed, table-driven bench for shift_out_register with N=6 (honours PARITY_EN if defined).
module tb_shift_out_register;

   localparam int N = 6;
`ifdef PARITY_EN
   localparam int SPACING = N + 2;
`else
   localparam int SPACING = N + 1;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         load_valid;
   logic         load_ready;
   logic [N-1:0] data;
   logic         bit_out;
   logic         bit_valid;
   logic         bit_ready;
   logic         bit_last;
   logic         busy;

   int errors = 0;
   int checks = 0;

   shift_out_register #(.N(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .data       (data),
      .bit_out    (bit_out),
      .bit_valid  (bit_valid),
      .bit_ready  (bit_ready),
      .bit_last   (bit_last),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // seq is written in emission order: leftmost digit is the first beat.
   typedef struct {
      logic [N-1:0] data;
      logic [N-1:0] seq;
      logic         par;
   } vec_t;

   vec_t vecs [6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_load_ready"}, int'(load_ready), 1);
      check({tag, "_bit_valid"},  int'(bit_valid),  0);
      check({tag, "_bit_out"},    int'(bit_out),    0);
      check({tag, "_bit_last"},   int'(bit_last),   0);
      check({tag, "_busy"},       int'(busy),       0);
   endtask

   task automatic check_beat(input string tag, input int i, input logic exp_bit);
      int exp_last;
`ifdef PARITY_EN
      exp_last = 0;
`else
      exp_last = (i == N - 1) ? 1 : 0;
`endif
      check($sformatf("%s_valid%0d", tag, i), int'(bit_valid),  1);
      check($sformatf("%s_bit%0d",   tag, i), int'(bit_out),    int'(exp_bit));
      check($sformatf("%s_last%0d",  tag, i), int'(bit_last),   exp_last);
      check($sformatf("%s_busy%0d",  tag, i), int'(busy),       1);
      check($sformatf("%s_lrdy%0d",  tag, i), int'(load_ready), 0);
   endtask

   // Load one word and drain it with bit_ready high; optionally offer junk loads while busy.
   task automatic run_word(input string tag, input logic [N-1:0] d, input logic [N-1:0] seq,
                           input logic par, input bit junk);
      load_valid = 1'b1;
      data       = d;
      step();
      load_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         check_beat(tag, i, seq[N-1-i]);
         if (junk && i < N - 1) begin
            load_valid = 1'b1;
            data       = '1;
         end else begin
            load_valid = 1'b0;
         end
         step();
      end
`ifdef PARITY_EN
      check({tag, "_par_valid"}, int'(bit_valid), 1);
      check({tag, "_par_bit"},   int'(bit_out),   int'(par));
      check({tag, "_par_last"},  int'(bit_last),  1);
      step();
`else
      if (par === 1'bx) $display("unused parity %0d", par);
`endif
      check_idle({tag, "_end"});
   endtask

   initial begin
      int hs0;
      int hs1;
      int waited;

      vecs[0] = '{data: 6'b101101, seq: 6'b101101, par: 1'b0};
      vecs[1] = '{data: 6'b000111, seq: 6'b111000, par: 1'b1};
      vecs[2] = '{data: 6'b000011, seq: 6'b110000, par: 1'b0};
      vecs[3] = '{data: 6'b100000, seq: 6'b000001, par: 1'b1};
      vecs[4] = '{data: 6'b111111, seq: 6'b111111, par: 1'b0};
      vecs[5] = '{data: 6'b010010, seq: 6'b010010, par: 1'b0};

      // Reset with a load offered: the load must be ignored.
      reset      = 1'b1;
      load_valid = 1'b1;
      data       = 6'b110011;
      bit_ready  = 1'b1;
      step();
      step();
      check_idle("reset");
      reset      = 1'b0;
      load_valid = 1'b0;
      step();
      check_idle("post_reset");

      for (int v = 0; v < 6; v++)
         run_word($sformatf("vec%0d", v), vecs[v].data, vecs[v].seq, vecs[v].par, 1'b0);

      // Backpressure on the third beat (bit 2 = 1) for three cycles.
      load_valid = 1'b1;
      data       = 6'b101101;
      step();
      load_valid = 1'b0;
      check_beat("bp", 0, 1'b1);
      step();
      check_beat("bp", 1, 1'b0);
      step();
      check_beat("bp", 2, 1'b1);
      bit_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         step();
         check_beat($sformatf("bp_hold%0d", s), 2, 1'b1);
      end
      bit_ready = 1'b1;
      step();
      check_beat("bp", 3, 1'b1);
      step();
      check_beat("bp", 4, 1'b0);
      step();
      check_beat("bp", 5, 1'b1);
      step();
`ifdef PARITY_EN
      check("bp_par_bit",  int'(bit_out),  0);
      check("bp_par_last", int'(bit_last), 1);
      step();
`endif
      check_idle("bp_end");

      // Loads offered while busy are ignored.
      run_word("busyload", 6'b101101, 6'b101101, 1'b0, 1'b1);

      // Reset in the middle of a word abandons it.
      load_valid = 1'b1;
      data       = 6'b101101;
      step();
      load_valid = 1'b0;
      check_beat("rst", 0, 1'b1);
      step();
      check_beat("rst", 1, 1'b0);
      step();
      check_beat("rst", 2, 1'b1);
      step();
      check_beat("rst", 3, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_idle("rst_mid");
      run_word("after_rst", 6'b000001, 6'b100000, 1'b1, 1'b0);

      // Back-to-back loads with load_valid held high.
      hs0 = -1;
      hs1 = -1;
      load_valid = 1'b1;
      data       = 6'b000111;
      for (int c = 0; c < 40; c++) begin
         if (load_ready && load_valid) begin
            if (hs0 < 0) begin
               hs0  = c;
               data = 6'b000011;
            end else begin
               hs1 = c;
            end
         end
         if (hs1 >= 0) break;
         step();
      end
      check("b2b_second_seen", int'(hs1 >= 0), 1);
      check("b2b_spacing", hs1 - hs0, SPACING);
      step();
      load_valid = 1'b0;
      check_beat("b2b_w2", 0, 1'b1);
      waited = 0;
      while (busy && waited < 20) begin
         step();
         waited++;
      end
      check("b2b_drain_bound", int'(waited < 20), 1);
      check_idle("b2b_end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_out_register.md
# shift_out_register

Parallel-in, serial-out register that drains a loaded N-bit word one bit per handshake, LSB first. It is the read-out side of the datapath's parallel load registers: it accepts a word through a valid/ready load port and presents it bit-serially to a downstream consumer with valid/ready flow control and an end-of-word flag. An optional even-parity beat can be appended after the data bits.

## Interface
- N, 6, data word width in bits (N >= 2)
- clk  in  1  rising-edge clock
- reset  in  1  reset; one clock, reset is synchronous and active-high
- load_valid  in  1  upstream offers a word on data
- load_ready  out  1  block can accept a word (high only in IDLE)
- data  in  N  word to serialize, sampled on load handshake
- bit_out  out  1  current serial bit
- bit_valid  out  1  bit_out is valid
- bit_ready  in  1  downstream accepts bit_out this cycle
- bit_last  out  1  current beat is the final beat of the word
- busy  out  1  word in progress (state != IDLE)

## Operation
- States: IDLE, SHIFT, PARITY (PARITY exists only with PARITY_EN).
- IDLE: load_ready=1, bit_valid=0, bit_out=0, bit_last=0. On load_valid & load_ready: capture data into shift register, load beat counter with N-1, compute even parity of data into a held parity bit, go to SHIFT.
- SHIFT: bit_valid=1, bit_out=shift_reg[0]. On bit_valid & bit_ready: shift right by one, decrement counter. If counter was 0 at the handshake: go to PARITY (PARITY_EN) or IDLE.
- PARITY: bit_valid=1, bit_out=parity bit (XOR of all N data bits), bit_last=1. On handshake go to IDLE.
- bit_last=1 on the beat where counter==0 in SHIFT without PARITY_EN; 0 on all data beats with PARITY_EN.
- Backpressure: while bit_valid & !bit_ready, bit_out, bit_valid, bit_last, state and counter hold unchanged.
- load_valid outside IDLE is ignored; data is not sampled; no overlap of words.
- All outputs registered or decoded from registered state only; no combinational path from any input to any output.
- Counter width $clog2(N); no wrap: counter never decrements below 0.

## Timing
- Reset (sampled on a rising edge with reset=1): state IDLE, shift register 0, counter 0, parity 0, bit_out 0, bit_valid 0, bit_last 0, busy 0. load_ready is 1 from the first cycle after reset deasserts; load_valid sampled while reset=1 is ignored.
- Reset mid-word: word is abandoned, no further beats; next cycle is IDLE.
- Load accepted at edge k: first beat (bit 0) valid in cycle k+1.
- With bit_ready held high: data beats in cycles k+1..k+N; IDLE (load_ready=1) in cycle k+N+1. With PARITY_EN, parity beat in cycle k+N+1, IDLE in k+N+2.
- Minimum spacing between load handshakes: N+1 cycles (N+2 with PARITY_EN).

## Configuration
- PARITY_EN defined: PARITY state compiled in; each word emits N data beats plus one even-parity beat carrying bit_last.
- PARITY_EN undefined: no PARITY state or parity register; N beats per word, bit_last on bit N-1.

## Test plan
- N=6, no PARITY_EN, bit_ready=1, load 6'b101101 -> bit_out 1,0,1,1,0,1 in cycles k+1..k+6, bit_last only in k+6, load_ready=1 in k+7.
- Backpressure: same word, bit_ready low for 3 cycles during beat 2 -> bit_out=1, bit_valid=1, bit_last=0 held for 3 cycles, sequence unchanged afterwards.
- Load while busy: load_valid=1 with data 6'b111111 during beats 1-5 -> ignored, output sequence of first word intact, busy=1 throughout.
- Reset at beat 3 -> next cycle bit_valid=0, bit_out=0, busy=0, load_ready=1; new load 6'b000001 emits 1,0,0,0,0,0 cleanly.
- PARITY_EN, load 6'b000111 -> beats 1,1,1,0,0,0 then parity 1 with bit_last=1; load 6'b000011 -> parity 0.
- Back-to-back: load_valid held high with two words -> second handshake exactly N+1 cycles (N+2 with PARITY_EN) after the first.
